// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode field type,
// mode encodings and a small mode-classification helper.
package usr_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t MODE_HOLD = 2'b00;
    localparam usr_mode_t MODE_SHR  = 2'b01;
    localparam usr_mode_t MODE_SHL  = 2'b10;
    localparam usr_mode_t MODE_LOAD = 2'b11;

    // True for the two modes that move data and advance the shift counter.
    function automatic logic is_shift(input usr_mode_t mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: a D cell behind a 4:1
// next-state mux (hold / value from the right-shift source / left-shift source / D).
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  logic      En,
    input  usr_mode_t Mode,
    input  logic      D,
    input  logic      ShrIn,
    input  logic      ShlIn,
    output logic      Q,
    output logic      Qn
);

    logic q_q;
    logic q_d;

    // NOTE: q_d gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        q_d = q_q;
        if (En) begin
            case (Mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = ShrIn;
                MODE_SHL:  q_d = ShlIn;
                MODE_LOAD: q_d = D;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment; reset is synchronous and outranks En.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign Qn = ~q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register (hold / shift right / shift left / load) with a
// saturating shift counter. Optional rotate input Rot is enabled by USR_ROTATE_EN.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  usr_mode_t        Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInR,
    input  logic             SerInL,
`ifdef USR_ROTATE_EN
    input  logic             Rot,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SerOutR,
    output logic             SerOutL,
    output logic [CNT_W-1:0] ShiftCnt,
    output logic             Drained
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic             shr_msb_in;
    logic             shl_lsb_in;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_full;

`ifdef USR_ROTATE_EN
    // Rotation recirculates the bit leaving the opposite end instead of the serial input.
    assign shr_msb_in = Rot ? q_w[0]       : SerInR;
    assign shl_lsb_in = Rot ? q_w[WIDTH-1] : SerInL;
`else
    assign shr_msb_in = SerInR;
    assign shl_lsb_in = SerInL;
`endif

    assign shr_src = {shr_msb_in, q_w[WIDTH-1:1]};
    assign shl_src = {q_w[WIDTH-2:0], shl_lsb_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell u_cell (
            .Clk   (Clk),
            .Reset (Reset),
            .En    (En),
            .Mode  (Mode),
            .D     (D[i]),
            .ShrIn (shr_src[i]),
            .ShlIn (shl_src[i]),
            .Q     (q_w[i]),
            .Qn    (qn_w[i])
        );
    end

    assign cnt_full = (cnt_q == CNT_W'(WIDTH));

    always_comb begin
        cnt_d = cnt_q;
        if (En) begin
            if (Mode == MODE_LOAD) begin
                cnt_d = '0;
            end else if (is_shift(Mode) && !cnt_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q        = q_w;
    assign Qn       = qn_w;
    assign SerOutR  = q_w[0];
    assign SerOutL  = q_w[WIDTH-1];
    assign ShiftCnt = cnt_q;
    assign Drained  = cnt_full;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios plus random
// traffic against an arithmetic reference model. Rotate stimulus under USR_ROTATE_EN.
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          Clk = 1'b0;
    logic          Reset;
    logic          En;
    logic [1:0]    Mode;
    logic [W-1:0]  D;
    logic          SerInR;
    logic          SerInL;
    logic          Rot;
    logic [W-1:0]  Q;
    logic [W-1:0]  Qn;
    logic          SerOutR;
    logic          SerOutL;
    logic [CW-1:0] ShiftCnt;
    logic          Drained;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_q;      // reference register value, 0 .. 2**W-1
    int m_cnt;    // reference shift count

    always #5 Clk = ~Clk;

    universal_shift_reg #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Mode     (Mode),
        .D        (D),
        .SerInR   (SerInR),
        .SerInL   (SerInL),
`ifdef USR_ROTATE_EN
        .Rot      (Rot),
`endif
        .Q        (Q),
        .Qn       (Qn),
        .SerOutR  (SerOutR),
        .SerOutL  (SerOutL),
        .ShiftCnt (ShiftCnt),
        .Drained  (Drained)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the register's rules, using integer arithmetic.
    task automatic model_edge();
        int  full;
        int  top;
        logic rot_now;
        full    = 1 << W;
        top     = 1 << (W - 1);
        rot_now = 1'b0;
`ifdef USR_ROTATE_EN
        rot_now = Rot;
`endif
        if (Reset) begin
            m_q   = 0;
            m_cnt = 0;
        end else if (En) begin
            if (Mode == 2'b01) begin
                int in_bit;
                in_bit = rot_now ? (m_q % 2) : int'(SerInR);
                m_q    = (m_q / 2) + in_bit * top;
                m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
            end else if (Mode == 2'b10) begin
                int in_bit;
                in_bit = rot_now ? (m_q / top) : int'(SerInL);
                m_q    = ((m_q * 2) % full) + in_bit;
                m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
            end else if (Mode == 2'b11) begin
                m_q   = int'(D);
                m_cnt = 0;
            end
        end
    endtask

    task automatic check_all();
        int full;
        full = 1 << W;
        check("Q",        32'(Q),        32'(m_q));
        check("Qn",       32'(Qn),       32'((full - 1) - m_q));
        check("SerOutR",  32'(SerOutR),  32'(m_q % 2));
        check("SerOutL",  32'(SerOutL),  32'(m_q / (1 << (W - 1))));
        check("ShiftCnt", 32'(ShiftCnt), 32'(m_cnt));
        check("Drained",  32'(Drained),  32'(m_cnt == W));
    endtask

    // One clock edge: update the model with the inputs seen at the edge, then sample.
    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                         input logic [W-1:0] d, input logic sr, input logic sl);
        Reset  = rst;
        En     = en;
        Mode   = mode;
        D      = d;
        SerInR = sr;
        SerInL = sl;
    endtask

    initial begin
        m_q   = 0;
        m_cnt = 0;
        Rot   = 1'b0;
        drive(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0);

        // Reset then load
        tick();
        check("rst_Q",   32'(Q),        32'h00);
        check("rst_Qn",  32'(Qn),       32'hFF);
        check("rst_cnt", 32'(ShiftCnt), 32'd0);
        drive(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
        tick();
        check("load_Q",  32'(Q),  32'hA5);
        check("load_Qn", 32'(Qn), 32'h5A);

        // Shift right three times with SerInR=1
        drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        check("shr_Q",    32'(Q),        32'hF4);
        check("shr_cnt",  32'(ShiftCnt), 32'd3);
        check("shr_sout", 32'(SerOutR),  32'd0);

        // Shift left to saturation and beyond
        drive(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e >= 8) begin
                check("sat_Q",   32'(Q),        32'h00);
                check("sat_cnt", 32'(ShiftCnt), 32'd8);
                check("sat_drn", 32'(Drained),  32'd1);
            end
        end

        // Load right after saturation clears the counter and Drained
        drive(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
        tick();
        check("reload_cnt", 32'(ShiftCnt), 32'd0);
        check("reload_drn", 32'(Drained),  32'd0);

        // En=0 holds despite a shift mode, then explicit hold
        drive(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1);
        repeat (4) tick();
        check("en0_Q",   32'(Q),        32'h3C);
        check("en0_cnt", 32'(ShiftCnt), 32'd0);
        drive(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1);
        tick();
        check("hold_Q", 32'(Q), 32'h3C);

        // Reset mid-sequence beats a simultaneous load
        drive(1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        check("mid_Q",   32'(Q),        32'h1F);
        check("mid_cnt", 32'(ShiftCnt), 32'd3);
        drive(1'b1, 1'b1, 2'b11, 8'h55, 1'b0, 1'b0);
        tick();
        check("rstld_Q",   32'(Q),        32'h00);
        check("rstld_cnt", 32'(ShiftCnt), 32'd0);
        drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
        tick();
        check("resume_cnt", 32'(ShiftCnt), 32'd1);

`ifdef USR_ROTATE_EN
        // Rotate right then left
        drive(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
        tick();
        Rot = 1'b1;
        drive(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        tick();
        check("rotr_Q", 32'(Q), 32'hC0);
        drive(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        check("rotl_Q",   32'(Q),        32'h03);
        check("rotl_cnt", 32'(ShiftCnt), 32'd3);
        Rot = 1'b0;
`endif

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)), W'($urandom), 1'($urandom), 1'($urandom));
`ifdef USR_ROTATE_EN
            Rot = 1'($urandom);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised N-bit register built from clocked D storage cells, with complementary outputs Q/Qn.
- Generalises the single-bit D flip-flop with four modes: hold, shift right, shift left and parallel load.
- Tracks the number of shifts since the last load or reset.
- Used as the ALU's operand/shift staging register, and as the next-generation storage element for serial/parallel conversion.

Parameters:
- WIDTH, 8, register width in bits (WIDTH >= 2).
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; not to be overridden).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- En  input  1  clock enable; 0 forces hold regardless of Mode.
- Mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SerInR  input  1  serial input entering at MSB on shift right.
- SerInL  input  1  serial input entering at LSB on shift left.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q.
- SerOutR  output  1  Q[0] (bit leaving on shift right).
- SerOutL  output  1  Q[WIDTH-1] (bit leaving on shift left).
- ShiftCnt  output  CNT_W  shifts since last load/reset, saturating at WIDTH.
- Drained  output  1  high when ShiftCnt == WIDTH.

Behaviour:
- All state updates on the rising edge of Clk. Outputs are registered or derived combinationally from registered state. Q changes one cycle after the qualifying edge inputs.
- Reset: synchronous, active-high, highest priority, overrides En and Mode. Reset values: Q=0, Qn=all ones, SerOutR=0, SerOutL=0, ShiftCnt=0, Drained=0.
- En=0: Q and ShiftCnt hold, whatever Mode is.
- Mode 00 (hold): Q and ShiftCnt unchanged.
- Mode 01 (shift right): Q <= {SerInR, Q[WIDTH-1:1]}; ShiftCnt increments, saturating at WIDTH.
- Mode 10 (shift left): Q <= {Q[WIDTH-2:0], SerInL}; ShiftCnt increments, saturating at WIDTH.
- Mode 11 (load): Q <= D; ShiftCnt <= 0.
- Qn is always exactly ~Q, including during and after reset. No cycle exists where Qn != ~Q.
- ShiftCnt counts shifts in either direction together. Mixed left/right shifts each add 1.
- Saturation: once ShiftCnt == WIDTH, further shifts leave it at WIDTH. Drained stays 1 until the next load or reset.
- Reset asserted mid-sequence (after k shifts): the next edge clears Q and ShiftCnt. Shifting resumes from zero on the first edge with Reset=0.
- Load in the cycle after saturation: ShiftCnt returns to 0 and Drained to 0 on that edge.
- No X propagation: with Reset applied for one edge, every output is defined.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: adds input port Rot (1 bit).
  - Rot=1 with Mode 01 feeds Q[0] into the MSB, ignoring SerInR.
  - Rot=1 with Mode 10 feeds Q[WIDTH-1] into the LSB, ignoring SerInL.
  - Rotates still increment ShiftCnt with saturation.
  - Rot is ignored in modes 00 and 11.
- Not defined: Rot port absent; shifts always take the serial inputs.

Decomposition:
- Package usr_pkg holds:
  - Mode encoding constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - A typedef for the 2-bit mode field.
- Sub-module usr_bit_cell: one storage bit with a 4:1 next-state mux (hold/right-neighbour/left-neighbour/D), Clk, Reset, En, and Q/Qn outputs. universal_shift_reg instantiates WIDTH cells in a generate loop.
- The shift counter and Drained logic live in the top level.

Test Plan:
- Reset then load: Reset=1 for 1 edge -> Q=8'h00, Qn=8'hFF, ShiftCnt=0. Then Mode=11, D=8'hA5, En=1 -> next edge Q=8'hA5, Qn=8'h5A, ShiftCnt=0.
- Shift right with serial input: from Q=8'hA5, Mode=01, SerInR=1 for 3 edges -> Q=8'hF4, ShiftCnt=3, SerOutR=0.
- Shift left to saturation: load 8'h81, Mode=10, SerInL=0 for 10 edges -> Q=8'h00 after 8 edges. ShiftCnt=8 and Drained=1 from edge 8, unchanged at edges 9-10.
- Enable/hold priority: Q=8'h3C, Mode=01, En=0 for 4 edges -> Q=8'h3C, ShiftCnt unchanged. Mode=00, En=1 -> still 8'h3C.
- Reset mid-operation: load 8'hFF, 3 right shifts with SerInR=0 (Q=8'h1F, ShiftCnt=3), then Reset=1 with Mode=11, D=8'h55 on one edge -> Q=8'h00, ShiftCnt=0 (reset beats load).
- USR_ROTATE_EN build:
  - Load 8'h81, Rot=1, Mode=01, 1 edge -> Q=8'hC0.
  - Then Mode=10, 2 edges -> Q=8'h03, ShiftCnt=3.
  - Without the macro, the same bench compiles with Rot stimulus removed.
